// File: rtl/seg_scan.sv
// seg_scan: seven-segment display scanner for the CPU debug display.
// The divider's clk_disp square wave is sampled as a level. It passes through a
// 2-flop synchroniser and a rising-edge detector, which together give a one-cycle
// scan tick. Each tick advances the active digit and opens an all-off blank gap
// of BLANK_CYCLES cycles, then drives the digit from a per-frame snapshot of
// data_i/dp_i. The snapshot is taken only on the wrap tick, so a frame never tears.
// Optional build macro SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression.
// When it is enabled, digit k (k >= 1) is dark if nibbles k..top are all zero and
// its dp is clear.
// All outputs are registered from next-state values. With B = BLANK_CYCLES, a
// digit appears B+1 cycles after its tick.
module seg_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clk_disp,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : CW'(0);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   dpr_q, dpr_d;
    logic                    s1, s2, s3;
    logic                    tick, wrap;
    logic                    blank_dig;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dpo_d;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Synchronise clk_disp into clk_i and keep one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_disp;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;
    assign wrap = tick && (idx_q == IDX_LAST);

    // Next state: a tick always advances the digit and restarts the gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dpr_d   = dpr_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
            if (wrap) begin
                data_d = data_i;
                dpr_d  = dp_i;
            end
            if (BLANK_CYCLES == 0) begin
                state_d = ST_DRIVE;
            end else begin
                state_d = ST_BLANK;
                cnt_d   = CNT_LOAD;
            end
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == '0) state_d = ST_DRIVE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = ST_DRIVE;
            endcase
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_zero;

    // Leading-zero mask of the snapshot that will be on display next cycle.
    always_comb begin
        lz_mask = '0;
        lz_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_zero    = lz_zero & (data_d[4*k +: 4] == 4'h0);
            lz_mask[k] = lz_zero & ~dpr_d[k];
        end
    end

    assign blank_dig = lz_mask[idx_d];
`else
    assign blank_dig = 1'b0;
`endif

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dpo_d = 1'b1;
        if (state_d == ST_DRIVE && !blank_dig) begin
            an_d[idx_d] = 1'b0;
            seg_d       = hex7(data_d[{idx_d, 2'b00} +: 4]);
            dpo_d       = ~dpr_d[idx_d];
        end
    end

    // State, counter, index, snapshot and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dpr_q   <= '0;
            an_o    <= '1;
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dpr_q   <= dpr_d;
            an_o    <= an_d;
            seg_o   <= seg_d;
            dp_o    <= dpo_d;
            frame_o <= wrap;
        end
    end

endmodule
